midi_voice_alloc: RTL and testbench
===================================

MIDI_VOICE_ALLOC -- requirements
Module: midi_voice_alloc

Interface
REQ-001 SHALL take parameter NUM_VOICES, default 8, number of polyphonic voice slots (2..16).
REQ-002 SHALL take parameter CHAN_MASK, default 16'hFFFF, bit n set = MIDI channel n accepted.
REQ-003 SHALL take parameter AGE_W, default 8, width of per-voice saturating age counter.
REQ-004 SHALL have ports: clk96 in 1, sole clock; rst_n in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: note_pressed in 1 and note_released in 1, single-cycle event strobes.
REQ-006 SHALL have ports: note in 7, velocity in 7, channel in 4, all qualified by either strobe.
REQ-007 SHALL have port all_off in 1, single-cycle strobe releasing every voice.
REQ-008 SHALL have ports: voice_active out NUM_VOICES; voice_note out 7*NUM_VOICES; voice_vel out 7*NUM_VOICES, packed with voice 0 at the LSBs.
REQ-009 SHALL have ports: gate_on out 1, gate_off out 1, single-cycle pulses; evt_voice out 4, index of the affected voice.
REQ-010 SHALL have ports: busy out 1; steal out 1, pulse accompanying gate_on when a voice is stolen; drop_cnt out 8.

Function
REQ-011 SHALL implement FSM IDLE -> SEARCH -> COMMIT -> IDLE; one event per pass; pass = 3 cycles.
REQ-012 SHALL, in IDLE, latch an accepted event into the working register and enter SEARCH the next cycle; busy=1 in SEARCH and COMMIT.
REQ-013 SHALL ignore events whose channel bit in CHAN_MASK is 0 (no state change, no count).
REQ-014 SHALL treat note_pressed with velocity 0 as note_released.
REQ-015 SHALL hold one pending event while busy; an event arriving with pending full SHALL be dropped and drop_cnt incremented, saturating at 255.
REQ-016 SHALL give note_released priority and ignore note_pressed when both strobe in the same cycle.
REQ-017 SHALL resolve note-on in SEARCH: (a) an active voice with equal note and channel is retriggered; else (b) the lowest-index inactive voice; else (c) the voice with the largest age, lowest index on ties, with steal=1.
REQ-018 SHALL, in COMMIT for note-on, write note/velocity/channel to the chosen voice, set voice_active, clear its age, saturating-increment the age of every other active voice, pulse gate_on, and drive evt_voice.
REQ-019 SHALL, for note-off, clear voice_active of the matching active voice (note and channel), pulse gate_off, and drive evt_voice; no match SHALL produce no pulse.
REQ-020 SHALL make gate_on/gate_off appear exactly 2 cycles after the strobe when IDLE and the pending register is empty.
REQ-021 SHALL process all_off at the next cycle boundary regardless of state: clear all voice_active, flush pending and working events, return to IDLE, and pulse gate_off with evt_voice=0.
REQ-022 SHALL hold voice_note/voice_vel unchanged on release (release tail keeps pitch).

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear FSM to IDLE, voice_active, all ages, pending, drop_cnt, voice_note, voice_vel, gate_on, gate_off, steal, busy, and evt_voice to 0.
REQ-024 SHALL discard any in-flight event on reset mid-pass; no pulse SHALL appear after rst_n rises until a new strobe arrives.

Structure
REQ-025 SHALL place the FSM state encoding and MIDI width constants (NOTE_W=7, CHAN_W=4) in the shared synth package.
REQ-026 SHALL implement victim selection (free-first, oldest-age, lowest-index) as one combinational sub-module voice_pick.

Verification
REQ-027 SHALL cover: note_pressed note=60 vel=100 ch=0 -> gate_on 2 cycles later, evt_voice=0, voice_active=8'h01.
REQ-028 SHALL cover: 9 distinct notes 60..68 ch0 (NUM_VOICES=8) -> 9th gives steal=1, evt_voice=0 (oldest), voice_note[6:0]=68.
REQ-029 SHALL cover: note_pressed note=60 vel=0 after note 60 held -> gate_off, voice_active bit cleared, voice_note retained at 60.
REQ-030 SHALL cover: three strobes on consecutive cycles -> first two processed, third dropped, drop_cnt=1.
REQ-031 SHALL cover: CHAN_MASK=16'h0001, note on ch=5 -> no gate_on, no state change; all_off with 4 active -> voice_active=0 next cycle.
REQ-032 SHALL cover: rst_n asserted during SEARCH -> outputs 0 immediately, no gate pulse after release.

Source files
------------

// File: rtl/midi_voice_alloc_pkg.sv
// Shared types and constants for the MIDI voice allocator.
// Event bundle, FSM encoding and MIDI field widths.
package midi_voice_alloc_pkg;

  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;
  localparam int CHAN_W = 4;
  localparam int EVT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  vel;
    logic [CHAN_W-1:0] chan;
  } midi_evt_t;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (&v) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/voice_pick.sv
// Victim selection for note-on: lowest free voice first,
// otherwise the oldest active voice (lowest index on ties).
module voice_pick
  import midi_voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int AGE_W      = 8
) (
  input  logic [NUM_VOICES-1:0]       active,
  input  logic [NUM_VOICES*AGE_W-1:0] ages,
  output logic [EVT_W-1:0]            idx,
  output logic                        steal
);

  logic             found;
  logic [EVT_W-1:0] free_idx;
  logic [EVT_W-1:0] old_idx;
  logic [AGE_W-1:0] old_age;

  always_comb begin
    found    = 1'b0;
    free_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!active[i] && !found) begin
        found    = 1'b1;
        free_idx = EVT_W'(i);
      end
    end
  end

  // Strict greater-than keeps the lowest index on equal ages.
  always_comb begin
    old_idx = '0;
    old_age = ages[AGE_W-1:0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (ages[i*AGE_W +: AGE_W] > old_age) begin
        old_age = ages[i*AGE_W +: AGE_W];
        old_idx = EVT_W'(i);
      end
    end
  end

  assign idx   = found ? free_idx : old_idx;
  assign steal = !found;

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic MIDI voice allocator: one event per
// IDLE/SEARCH/COMMIT pass, one pending slot, all_off flush.
module midi_voice_alloc
  import midi_voice_alloc_pkg::*;
#(
  parameter int          NUM_VOICES = 8,
  parameter logic [15:0] CHAN_MASK  = 16'hFFFF,
  parameter int          AGE_W      = 8
) (
  input  logic                         clk96,
  input  logic                         rst_n,
  input  logic                         note_pressed,
  input  logic                         note_released,
  input  logic [NOTE_W-1:0]            note,
  input  logic [VEL_W-1:0]             velocity,
  input  logic [CHAN_W-1:0]            channel,
  input  logic                         all_off,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [VEL_W*NUM_VOICES-1:0]  voice_vel,
  output logic                         gate_on,
  output logic                         gate_off,
  output logic [EVT_W-1:0]             evt_voice,
  output logic                         busy,
  output logic                         steal,
  output logic [7:0]                   drop_cnt
);

  state_e          state_q, state_d;
  midi_evt_t       work_q, work_d;
  midi_evt_t       pend_q, pend_d;
  logic            pend_v_q, pend_v_d;
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [AGE_W-1:0]  age_q  [NUM_VOICES];
  logic [AGE_W-1:0]  age_d  [NUM_VOICES];
  logic [NOTE_W-1:0] note_q [NUM_VOICES];
  logic [NOTE_W-1:0] note_d [NUM_VOICES];
  logic [VEL_W-1:0]  vel_q  [NUM_VOICES];
  logic [VEL_W-1:0]  vel_d  [NUM_VOICES];
  logic [CHAN_W-1:0] chan_q [NUM_VOICES];
  logic [CHAN_W-1:0] chan_d [NUM_VOICES];
  logic            gate_on_q, gate_on_d;
  logic            gate_off_q, gate_off_d;
  logic            steal_q, steal_d;
  logic            busy_q, busy_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic [7:0]      drop_q, drop_d;

  logic            accept;
  midi_evt_t       in_evt;
  logic [NUM_VOICES*AGE_W-1:0] ages_flat;
  logic [EVT_W-1:0] pick_idx;
  logic            pick_steal;
  logic            hit;
  logic [EVT_W-1:0] hit_idx;
  logic [EVT_W-1:0] tgt;

  // Velocity-0 note-on is a release; release wins a double strobe.
  assign accept = (note_pressed | note_released) & CHAN_MASK[channel];
  assign in_evt = {note_pressed & ~note_released & (|velocity),
                   note, velocity, channel};

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign ages_flat[g*AGE_W +: AGE_W]   = age_q[g];
    assign voice_note[g*NOTE_W +: NOTE_W] = note_q[g];
    assign voice_vel[g*VEL_W +: VEL_W]    = vel_q[g];
  end

  voice_pick #(
    .NUM_VOICES(NUM_VOICES),
    .AGE_W     (AGE_W)
  ) u_voice_pick (
    .active(active_q),
    .ages  (ages_flat),
    .idx   (pick_idx),
    .steal (pick_steal)
  );

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!hit && active_q[i] &&
          note_q[i] == work_q.note &&
          chan_q[i] == work_q.chan) begin
        hit     = 1'b1;
        hit_idx = EVT_W'(i);
      end
    end
  end

  assign tgt = hit ? hit_idx : pick_idx;

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    active_d   = active_q;
    age_d      = age_q;
    note_d     = note_q;
    vel_d      = vel_q;
    chan_d     = chan_q;
    gate_on_d  = 1'b0;
    gate_off_d = 1'b0;
    steal_d    = 1'b0;
    evt_d      = evt_q;
    drop_d     = drop_q;
    if (all_off) begin
      state_d    = S_IDLE;
      work_d     = '0;
      pend_v_d   = 1'b0;
      active_d   = '0;
      gate_off_d = 1'b1;
      evt_d      = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        age_d[i] = '0;
      end
    end else begin
      if (accept && state_q != S_IDLE) begin
        if (pend_v_q) begin
          drop_d = sat_inc8(drop_q);
        end else begin
          pend_d   = in_evt;
          pend_v_d = 1'b1;
        end
      end
      unique case (state_q)
        S_IDLE: begin
          if (pend_v_q) begin
            work_d   = pend_q;
            state_d  = S_SEARCH;
            pend_d   = in_evt;
            pend_v_d = accept;
          end else if (accept) begin
            work_d  = in_evt;
            state_d = S_SEARCH;
          end
        end
        S_SEARCH: begin
          state_d = S_COMMIT;
          if (work_q.on) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (tgt == EVT_W'(i)) begin
                active_d[i] = 1'b1;
                age_d[i]    = '0;
                note_d[i]   = work_q.note;
                vel_d[i]    = work_q.vel;
                chan_d[i]   = work_q.chan;
              end else if (active_q[i] && !(&age_q[i])) begin
                age_d[i] = age_q[i] + 1'b1;
              end
            end
            gate_on_d = 1'b1;
            steal_d   = !hit && pick_steal;
            evt_d     = tgt;
          end else if (hit) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (hit_idx == EVT_W'(i)) active_d[i] = 1'b0;
            end
            gate_off_d = 1'b1;
            evt_d      = hit_idx;
          end
        end
        S_COMMIT: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk96 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      work_q     <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      active_q   <= '0;
      gate_on_q  <= 1'b0;
      gate_off_q <= 1'b0;
      steal_q    <= 1'b0;
      busy_q     <= 1'b0;
      evt_q      <= '0;
      drop_q     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        age_q[i]  <= '0;
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        chan_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      active_q   <= active_d;
      gate_on_q  <= gate_on_d;
      gate_off_q <= gate_off_d;
      steal_q    <= steal_d;
      busy_q     <= busy_d;
      evt_q      <= evt_d;
      drop_q     <= drop_d;
      age_q      <= age_d;
      note_q     <= note_d;
      vel_q      <= vel_d;
      chan_q     <= chan_d;
    end
  end

  assign voice_active = active_q;
  assign gate_on      = gate_on_q;
  assign gate_off     = gate_off_q;
  assign steal        = steal_q;
  assign busy         = busy_q;
  assign evt_voice    = evt_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed bench for midi_voice_alloc: default instance
// plus a channel-0-only instance sharing the same stimulus.
module tb_midi_voice_alloc;

  logic       clk96 = 1'b0;
  logic       rst_n = 1'b0;
  logic       np = 1'b0;
  logic       nr = 1'b0;
  logic       aoff = 1'b0;
  logic [6:0] note = '0;
  logic [6:0] vel = '0;
  logic [3:0] ch = '0;

  logic [7:0]  act, m_act;
  logic [55:0] vnote, m_vnote;
  logic [55:0] vvel, m_vvel;
  logic        gon, m_gon;
  logic        goff, m_goff;
  logic [3:0]  evt, m_evt;
  logic        busy, m_busy;
  logic        stl, m_stl;
  logic [7:0]  drop, m_drop;

  int nchk = 0;
  int nerr = 0;
  logic pulse;

  always #5 clk96 = ~clk96;

  midi_voice_alloc dut (
    .clk96(clk96), .rst_n(rst_n),
    .note_pressed(np), .note_released(nr),
    .note(note), .velocity(vel), .channel(ch),
    .all_off(aoff),
    .voice_active(act), .voice_note(vnote),
    .voice_vel(vvel), .gate_on(gon),
    .gate_off(goff), .evt_voice(evt),
    .busy(busy), .steal(stl), .drop_cnt(drop)
  );

  midi_voice_alloc #(.CHAN_MASK(16'h0001)) dut_m (
    .clk96(clk96), .rst_n(rst_n),
    .note_pressed(np), .note_released(nr),
    .note(note), .velocity(vel), .channel(ch),
    .all_off(aoff),
    .voice_active(m_act), .voice_note(m_vnote),
    .voice_vel(m_vvel), .gate_on(m_gon),
    .gate_off(m_goff), .evt_voice(m_evt),
    .busy(m_busy), .steal(m_stl), .drop_cnt(m_drop)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk96);
    #1;
  endtask

  // Strobe held for one cycle; returns in the SEARCH cycle.
  task automatic strobe(
    input logic       p,
    input logic       r,
    input logic [6:0] n,
    input logic [6:0] v,
    input logic [3:0] c
  );
    np = p; nr = r; note = n; vel = v; ch = c;
    tick();
    np = 1'b0; nr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk96);
    #1;
    check("rst_active", 64'(act), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_drop", 64'(drop), 64'h0);
    check("rst_pulses", 64'({gon, goff, stl}), 64'h0);
    check("rst_vnote", 64'(vnote), 64'h0);
    check("rst_vvel", 64'(vvel), 64'h0);
    rst_n = 1'b1;
    tick();

    strobe(1, 0, 7'd60, 7'd100, 4'd0);
    check("on_busy", 64'(busy), 64'h1);
    check("on_early", 64'(gon), 64'h0);
    tick();
    check("on_gate", 64'(gon), 64'h1);
    check("on_evt", 64'(evt), 64'h0);
    check("on_active", 64'(act), 64'h01);
    check("on_steal", 64'(stl), 64'h0);
    tick();
    check("on_done", 64'({gon, busy}), 64'h0);

    strobe(1, 0, 7'd60, 7'd0, 4'd0);
    tick();
    check("v0_goff", 64'(goff), 64'h1);
    check("v0_gon", 64'(gon), 64'h0);
    check("v0_evt", 64'(evt), 64'h0);
    check("v0_active", 64'(act), 64'h0);
    check("v0_note", 64'(vnote[6:0]), 64'd60);
    check("v0_vel", 64'(vvel[6:0]), 64'd100);
    tick();

    for (int i = 0; i < 8; i++) begin
      strobe(1, 0, 7'(60 + i), 7'd100, 4'd0);
      tick();
      check("fill_evt", 64'(evt), 64'(i));
      tick();
    end
    check("fill_act", 64'(act), 64'hFF);

    strobe(1, 0, 7'd68, 7'd100, 4'd0);
    tick();
    check("steal_flag", 64'(stl), 64'h1);
    check("steal_evt", 64'(evt), 64'h0);
    check("steal_note", 64'(vnote[6:0]), 64'd68);
    check("steal_keep", 64'(vnote[13:7]), 64'd61);
    tick();

    strobe(1, 0, 7'd63, 7'd50, 4'd0);
    tick();
    check("retrig_evt", 64'(evt), 64'h3);
    check("retrig_stl", 64'(stl), 64'h0);
    check("retrig_vel", 64'(vvel[27:21]), 64'd50);
    tick();

    strobe(1, 0, 7'd70, 7'd100, 4'd0);
    tick();
    check("steal2_flag", 64'(stl), 64'h1);
    check("steal2_evt", 64'(evt), 64'h1);
    tick();

    nr = 1'b1; np = 1'b0; ch = 4'd0; note = 7'd62;
    tick();
    note = 7'd64;
    tick();
    check("burst_goff1", 64'(goff), 64'h1);
    check("burst_evt1", 64'(evt), 64'h2);
    note = 7'd66;
    tick();
    nr = 1'b0;
    check("burst_drop", 64'(drop), 64'h1);
    tick();
    tick();
    check("burst_goff2", 64'(goff), 64'h1);
    check("burst_evt2", 64'(evt), 64'h4);
    tick();
    check("burst_act", 64'(act), 64'hEB);
    check("burst_drop2", 64'(drop), 64'h1);

    strobe(0, 1, 7'd68, 7'd0, 4'd0);
    tick(); tick();
    strobe(0, 1, 7'd70, 7'd0, 4'd0);
    tick(); tick();
    check("four_act", 64'(act), 64'hE8);

    strobe(1, 0, 7'd72, 7'd100, 4'd0);
    aoff = 1'b1;
    tick();
    aoff = 1'b0;
    check("aoff_act", 64'(act), 64'h0);
    check("aoff_goff", 64'(goff), 64'h1);
    check("aoff_evt", 64'(evt), 64'h0);
    check("aoff_idle", 64'({gon, busy}), 64'h0);
    tick();
    check("aoff_quiet", 64'({gon, goff, busy}), 64'h0);
    tick();
    check("aoff_flush", 64'({gon, act}), 64'h0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    strobe(1, 0, 7'd40, 7'd90, 4'd5);
    check("mask_busy", 64'(m_busy), 64'h0);
    check("full_busy", 64'(busy), 64'h1);
    tick();
    check("mask_none", 64'({m_act, m_gon, m_goff,
      m_stl, m_evt, m_drop}), 64'h0);
    check("mask_vals", 64'(m_vnote | m_vvel), 64'h0);
    check("full_gon", 64'(gon), 64'h1);
    check("full_act", 64'(act), 64'h01);
    tick();

    strobe(1, 1, 7'd40, 7'd90, 4'd5);
    tick();
    check("both_goff", 64'({gon, goff}), 64'h1);
    check("both_evt", 64'(evt), 64'h0);
    check("both_act", 64'(act), 64'h0);
    tick();

    strobe(1, 0, 7'd50, 7'd100, 4'd0);
    check("pre_rst_busy", 64'({busy, m_busy}), 64'h3);
    rst_n = 1'b0;
    #1;
    check("rst_async", 64'({act, busy, gon, goff, stl,
      evt, m_busy}), 64'h0);
    #2;
    rst_n = 1'b1;
    pulse = 1'b0;
    repeat (4) begin
      tick();
      if (gon | goff | m_gon | m_goff) pulse = 1'b1;
    end
    check("rst_nopulse", 64'(pulse), 64'h0);
    check("rst_act_after", 64'({act, m_act}), 64'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
